// File: rtl/ast_to_bt656_if.sv
// rtl/ast_to_bt656_if.sv - Avalon-ST video sink bundle feeding ast_to_bt656
// Ports: st_data[7:0], st_valid, st_sop, st_eop from the source; st_ready from the sink.
interface ast_to_bt656_if;
  logic [7:0] st_data;
  logic       st_valid;
  logic       st_sop;
  logic       st_eop;
  logic       st_ready;

  modport master (output st_data, st_valid, st_sop, st_eop, input st_ready);
  modport slave  (input st_data, st_valid, st_sop, st_eop, output st_ready);
endinterface

// File: rtl/ast_to_bt656.sv
// rtl/ast_to_bt656.sv - Avalon-ST video to ITU-R BT.656 byte stream generator
// Ports: clock, reset (async, active low); st (Avalon-ST sink, slave modport);
//        bt_data/bt_f/bt_v/bt_h registered BT.656 byte and flags;
//        underflow, frame_err one-cycle registered pulses aligned with bt_data.
module ast_to_bt656 #(
  parameter int LINE_BYTES   = 1728,
  parameter int ACTIVE_BYTES = 1440,
  parameter int FRAME_LINES  = 625,
  parameter int F2_START     = 313,
  parameter int F1_FIRST     = 23,
  parameter int F1_LAST      = 310,
  parameter int F2_FIRST     = 336,
  parameter int F2_LAST      = 623
) (
  input  logic                 clock,
  input  logic                 reset,
  ast_to_bt656_if.slave        st,
  output logic [7:0]           bt_data,
  output logic                 bt_f,
  output logic                 bt_v,
  output logic                 bt_h,
  output logic                 underflow,
  output logic                 frame_err
);

  localparam int HW        = $clog2(LINE_BYTES);
  localparam int LW        = $clog2(FRAME_LINES + 1);
  localparam int ACT_START = LINE_BYTES - ACTIVE_BYTES;
  localparam int SAV_START = ACT_START - 4;
  // Active fill parity is counted from the first active byte, not from hcnt.
  localparam logic ACT_ODD = (ACT_START % 2) == 1;

  typedef enum logic {WAIT_SOP, RUN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [7:0]    bt_data_q, bt_data_d;
  logic          bt_f_q, bt_f_d;
  logic          bt_v_q, bt_v_d;
  logic          bt_h_q, bt_h_d;
  logic          underflow_q, underflow_d;
  logic          frame_err_q, frame_err_d;

  logic       f_c, v_c, h_c, act_line, in_active, fill_odd;
  logic       slot, at_first, frame_end, take, ready_c;
  logic [7:0] xy_c, fill_c, timing_c, clip_c;

  // Position decode and the byte the timing generator would emit here.
  always_comb begin
    f_c       = line_q >= LW'(F2_START);
    act_line  = (line_q >= LW'(F1_FIRST) && line_q <= LW'(F1_LAST)) ||
                (line_q >= LW'(F2_FIRST) && line_q <= LW'(F2_LAST));
    v_c       = !act_line;
    in_active = hcnt_q >= HW'(ACT_START);
    // H covers EAV and horizontal blanking; it drops from SAV onward.
    h_c       = hcnt_q < HW'(SAV_START);
    xy_c      = {1'b1, f_c, v_c, h_c, v_c ^ h_c, f_c ^ h_c, f_c ^ v_c, f_c ^ v_c ^ h_c};
    fill_odd  = in_active ? (hcnt_q[0] ^ ACT_ODD) : hcnt_q[0];
    fill_c    = fill_odd ? 8'h10 : 8'h80;

    timing_c = fill_c;
    if (hcnt_q == HW'(0) || hcnt_q == HW'(SAV_START))
      timing_c = 8'hFF;
    else if (hcnt_q == HW'(1) || hcnt_q == HW'(2) ||
             hcnt_q == HW'(SAV_START + 1) || hcnt_q == HW'(SAV_START + 2))
      timing_c = 8'h00;
    else if (hcnt_q == HW'(3) || hcnt_q == HW'(SAV_START + 3))
      timing_c = xy_c;

    // 00 and FF are reserved for timing references.
    clip_c = st.st_data;
    if (st.st_data == 8'h00)
      clip_c = 8'h01;
    else if (st.st_data == 8'hFF)
      clip_c = 8'hFE;

    slot      = in_active && act_line;
    at_first  = line_q == LW'(F1_FIRST) && hcnt_q == HW'(ACT_START);
    frame_end = line_q == LW'(F2_LAST) && hcnt_q == HW'(LINE_BYTES - 1);
  end

  // Free-running counters; they never stall on the sink.
  always_comb begin
    hcnt_d = hcnt_q + HW'(1);
    line_d = line_q;
    if (hcnt_q == HW'(LINE_BYTES - 1)) begin
      hcnt_d = '0;
      line_d = (line_q == LW'(FRAME_LINES)) ? LW'(1) : line_q + LW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    ready_c     = 1'b0;
    take        = 1'b0;
    underflow_d = 1'b0;
    frame_err_d = 1'b0;
    bt_data_d   = timing_c;
    bt_f_d      = f_c;
    bt_v_d      = v_c;
    bt_h_d      = h_c;

    case (state_q)
      WAIT_SOP: begin
        if (st.st_valid) begin
          if (!st.st_sop) begin
            ready_c = 1'b1;                 // drop stray beats between frames
          end else if (at_first) begin
            ready_c = 1'b1;                 // held sop beat released into line F1_FIRST
            take    = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (slot) begin
          if (!st.st_valid) begin
            underflow_d = 1'b1;             // timing_c already holds active fill
          end else if (st.st_sop) begin
            frame_err_d = 1'b1;             // new frame started early; leave it held
            state_d     = WAIT_SOP;
          end else begin
            ready_c = 1'b1;
            take    = 1'b1;
          end
        end
      end
      default: state_d = WAIT_SOP;
    endcase

    if (take) begin
      bt_data_d = clip_c;
      if (st.st_eop) begin
        state_d     = WAIT_SOP;
        frame_err_d = !frame_end;
      end else if (frame_end) begin
        state_d     = WAIT_SOP;
        frame_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_SOP;
      hcnt_q      <= '0;
      line_q      <= LW'(1);
      bt_data_q   <= 8'h10;
      bt_f_q      <= 1'b0;
      bt_v_q      <= 1'b1;
      bt_h_q      <= 1'b1;
      underflow_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      line_q      <= line_d;
      bt_data_q   <= bt_data_d;
      bt_f_q      <= bt_f_d;
      bt_v_q      <= bt_v_d;
      bt_h_q      <= bt_h_d;
      underflow_q <= underflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Ready is forced low while reset is held so no beat can slip in.
  assign st.st_ready = ready_c & reset;
  assign bt_data     = bt_data_q;
  assign bt_f        = bt_f_q;
  assign bt_v        = bt_v_q;
  assign bt_h        = bt_h_q;
  assign underflow   = underflow_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ast_to_bt656.sv
// tb/tb_ast_to_bt656.sv - directed self-checking bench for ast_to_bt656 on a reduced raster
module tb_ast_to_bt656;
  localparam int LB = 32, AB = 16, FL = 20, F2S = 11, F1F = 3, F1L = 8, F2F = 13, F2L = 18;
  localparam int FRAME = LB * FL;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] bt_data;
  logic       bt_f, bt_v, bt_h, underflow, frame_err;

  ast_to_bt656_if st_if();

  ast_to_bt656 #(
    .LINE_BYTES(LB), .ACTIVE_BYTES(AB), .FRAME_LINES(FL), .F2_START(F2S),
    .F1_FIRST(F1F), .F1_LAST(F1L), .F2_FIRST(F2F), .F2_LAST(F2L)
  ) dut (
    .clock(clock), .reset(reset), .st(st_if),
    .bt_data(bt_data), .bt_f(bt_f), .bt_v(bt_v), .bt_h(bt_h),
    .underflow(underflow), .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         line;
    int         hc;
    logic [7:0] d;
    logic       chk;
    logic       f;
    logic       v;
    logic       h;
  } vec_t;

  vec_t       tbl[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         pos, outpos;
  logic       rdy;
  logic [7:0] cap_d [0:FRAME-1];
  logic [2:0] cap_fvh [0:FRAME-1];
  logic [7:0] got_b [0:255];
  logic [7:0] gapb [0:2];
  int         k_done, first_pos, last_pos, mism, n_uf, n_fe;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input int l, input int h, input logic [7:0] d, input logic c,
                     input logic f, input logic v, input logic hf);
    vec_t e;
    e.line = l; e.hc = h; e.d = d; e.chk = c; e.f = f; e.v = v; e.h = hf;
    tbl.push_back(e);
  endtask

  function automatic logic [7:0] beat(input int k);
    return 8'(k + 200);
  endfunction

  function automatic logic [7:0] clip(input logic [7:0] d);
    if (d == 8'h00) return 8'h01;
    if (d == 8'hFF) return 8'hFE;
    return d;
  endfunction

  // One clock: sample ready with inputs settled, then observe the byte for position pos.
  task automatic cyc();
    #1;
    rdy = st_if.st_ready;
    @(posedge clock);
    #1;
    outpos = pos;
    pos++;
  endtask

  task automatic drive_frame(input int nbeats, input int gap_at, input int gap_len);
    int k;
    int budget;
    int p;
    k = 0; budget = 0; first_pos = -1; last_pos = -1; mism = 0; n_uf = 0; n_fe = 0;
    while (k < nbeats && budget < 3 * FRAME) begin
      p = pos % FRAME;
      st_if.st_valid = !(p >= gap_at && p < gap_at + gap_len);
      st_if.st_sop   = (k == 0);
      st_if.st_eop   = (k == nbeats - 1);
      st_if.st_data  = beat(k);
      cyc();
      budget++;
      if (underflow) n_uf++;
      if (frame_err) n_fe++;
      if (p >= gap_at && p < gap_at + gap_len) gapb[p - gap_at] = bt_data;
      if (rdy && st_if.st_valid) begin
        if (k == 0) first_pos = outpos % FRAME;
        last_pos = outpos % FRAME;
        got_b[k] = bt_data;
        if (bt_data !== clip(beat(k))) mism++;
        k++;
      end
    end
    k_done = k;
    st_if.st_valid = 1'b0;
    st_if.st_sop   = 1'b0;
    st_if.st_eop   = 1'b0;
  endtask

  initial begin
    int bad_rdy, bad_pulse, idx, budget;
    logic [7:0] b240, b241, b400;
    logic found;

    add(1, 0, 8'hFF, 0, 0, 0, 0);  add(1, 1, 8'h00, 0, 0, 0, 0);
    add(1, 2, 8'h00, 0, 0, 0, 0);  add(1, 3, 8'hB6, 1, 0, 1, 1);
    add(1, 4, 8'h80, 0, 0, 0, 0);  add(1, 5, 8'h10, 0, 0, 0, 0);
    add(1, 11, 8'h10, 0, 0, 0, 0); add(1, 12, 8'hFF, 0, 0, 0, 0);
    add(1, 13, 8'h00, 0, 0, 0, 0); add(1, 14, 8'h00, 0, 0, 0, 0);
    add(1, 15, 8'hAB, 1, 0, 1, 0); add(1, 16, 8'h80, 0, 0, 0, 0);
    add(1, 17, 8'h10, 0, 0, 0, 0); add(1, 31, 8'h10, 0, 0, 0, 0);
    add(2, 15, 8'hAB, 1, 0, 1, 0); add(3, 3, 8'h9D, 1, 0, 0, 1);
    add(3, 15, 8'h80, 1, 0, 0, 0); add(3, 16, 8'h80, 0, 0, 0, 0);
    add(3, 31, 8'h10, 0, 0, 0, 0); add(8, 15, 8'h80, 1, 0, 0, 0);
    add(9, 3, 8'hB6, 1, 0, 1, 1);  add(10, 15, 8'hAB, 1, 0, 1, 0);
    add(11, 3, 8'hF1, 1, 1, 1, 1); add(11, 15, 8'hEC, 1, 1, 1, 0);
    add(12, 3, 8'hF1, 1, 1, 1, 1); add(13, 3, 8'hDA, 1, 1, 0, 1);
    add(13, 15, 8'hC7, 1, 1, 0, 0); add(18, 15, 8'hC7, 1, 1, 0, 0);
    add(19, 3, 8'hF1, 1, 1, 1, 1); add(20, 15, 8'hEC, 1, 1, 1, 0);
    add(20, 31, 8'h10, 0, 0, 0, 0);

    st_if.st_valid = 1'b0; st_if.st_sop = 1'b0; st_if.st_eop = 1'b0; st_if.st_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    st_if.st_valid = 1'b1;
    #1;
    check("reset_ready", st_if.st_ready, 0);
    st_if.st_valid = 1'b0;
    check("reset_bt_data", bt_data, 8'h10);
    check("reset_fvh", {bt_f, bt_v, bt_h}, 3'b011);
    check("reset_pulses", {underflow, frame_err}, 2'b00);

    // Idle frame, st_valid low throughout.
    @(negedge clock); reset = 1'b1; pos = 0;
    bad_rdy = 0; bad_pulse = 0;
    for (int i = 0; i < FRAME; i++) begin
      cyc();
      cap_d[outpos]   = bt_data;
      cap_fvh[outpos] = {bt_f, bt_v, bt_h};
      if (rdy) bad_rdy++;
      if (underflow || frame_err) bad_pulse++;
    end
    check("idle_ready_count", bad_rdy, 0);
    check("idle_pulse_count", bad_pulse, 0);
    foreach (tbl[i]) begin
      idx = (tbl[i].line - 1) * LB + tbl[i].hc;
      check($sformatf("vec%0d_l%0d_h%0d_data", i, tbl[i].line, tbl[i].hc), cap_d[idx], tbl[i].d);
      if (tbl[i].chk)
        check($sformatf("vec%0d_l%0d_h%0d_fvh", i, tbl[i].line, tbl[i].hc),
              cap_fvh[idx], {tbl[i].f, tbl[i].v, tbl[i].h});
    end
    cyc();
    check("wrap_eav_ff", bt_data, 8'hFF);
    repeat (3) cyc();
    check("wrap_eav_xy", bt_data, 8'hB6);

    // Restart, then stray beats before the first sop.
    reset = 1'b0;
    @(negedge clock); reset = 1'b1; pos = 0;
    bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      st_if.st_valid = 1'b1; st_if.st_sop = 1'b0; st_if.st_data = 8'(8'hA0 + i);
      cyc();
      if (!rdy) bad_rdy++;
    end
    check("garbage_dropped", bad_rdy, 0);

    // Full frame, valid always high.
    drive_frame(192, -10, 0);
    check("fa_beats", k_done, 192);
    check("fa_first_pos", first_pos, 2 * LB + 16);
    check("fa_last_pos", last_pos, 17 * LB + 31);
    check("fa_data_mism", mism, 0);
    check("fa_pulses", {n_uf[15:0], n_fe[15:0]}, 0);
    check("fa_clip_ff", got_b[55], 8'hFE);
    check("fa_clip_00", got_b[56], 8'h01);

    st_if.st_valid = 1'b1; st_if.st_sop = 1'b0;
    cyc();
    check("post_eop_discard", rdy, 1);
    st_if.st_valid = 1'b0;

    // Three-cycle underflow inside line 5; frame is three beats short to stay aligned.
    drive_frame(189, 4 * LB + 21, 3);
    check("fb_beats", k_done, 189);
    check("fb_first_pos", first_pos, 2 * LB + 16);
    check("fb_last_pos", last_pos, 17 * LB + 31);
    check("fb_data_mism", mism, 0);
    check("fb_underflow_pulses", n_uf, 3);
    check("fb_frame_err", n_fe, 0);
    check("fb_gap_fill", {gapb[0], gapb[1], gapb[2]}, 24'h108010);

    // eop early on line 7.
    drive_frame(71, -10, 0);
    check("fc_beats", k_done, 71);
    check("fc_eop_pos", last_pos, 6 * LB + 22);
    check("fc_frame_err", n_fe, 1);
    check("fc_data_mism", mism, 0);
    found = 1'b0; budget = 0; bad_pulse = 0;
    b240 = 8'h00; b241 = 8'h00; b400 = 8'h00;
    while (!found && budget < 2 * FRAME) begin
      cyc();
      budget++;
      if (underflow || frame_err) bad_pulse++;
      if (outpos % FRAME == 240) b240 = bt_data;
      if (outpos % FRAME == 241) b241 = bt_data;
      if (outpos % FRAME == 400) begin b400 = bt_data; found = 1'b1; end
    end
    check("fc_wait_bound", found, 1);
    check("fc_line8_blank", {b240, b241}, 16'h8010);
    check("fc_line13_blank", b400, 8'h80);
    check("fc_no_pulses", bad_pulse, 0);

    // Asynchronous reset while line 12 EAV code is on the output.
    found = 1'b0; budget = 0;
    while (!found && budget < 2 * FRAME) begin
      cyc();
      budget++;
      if (outpos % FRAME == 11 * LB + 3) found = 1'b1;
    end
    check("mid_wait_bound", found, 1);
    check("mid_pre_reset_code", {bt_f, bt_data}, 9'h1F1);
    st_if.st_valid = 1'b1; st_if.st_sop = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("mid_reset_data", bt_data, 8'h10);
    check("mid_reset_fvh", {bt_f, bt_v, bt_h}, 3'b011);
    check("mid_reset_ready", st_if.st_ready, 0);
    st_if.st_valid = 1'b0;
    @(negedge clock); reset = 1'b1; pos = 0;
    cyc();
    check("restart_eav_ff", bt_data, 8'hFF);
    repeat (3) cyc();
    check("restart_eav_xy", bt_data, 8'hB6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
